// File: rtl/count_seg_pkg.sv
// Shared types and constants for the two-digit seven-segment count display.
package count_seg_pkg;

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } dig_t;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] AN_OFF = 4'b1111;

  function automatic logic [3:0] an_for(input dig_t d);
    return ~(4'b0001 << d);
  endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Decimal digit to active-low seven-segment pattern; values above 9 are blank.
module bcd_to_seg
  import count_seg_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_digit)
      4'd0: o_seg = SEG_0;
      4'd1: o_seg = SEG_1;
      4'd2: o_seg = SEG_2;
      4'd3: o_seg = SEG_3;
      4'd4: o_seg = SEG_4;
      4'd5: o_seg = SEG_5;
      4'd6: o_seg = SEG_6;
      4'd7: o_seg = SEG_7;
      4'd8: o_seg = SEG_8;
      4'd9: o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/count_seg_display.sv
// Scans a snapshotted 4-bit count onto the two rightmost digits of a 4-digit display.
// Optional: define COUNT_SEG_CHANGE_DP_EN to light the rightmost dp for one frame after a change.
module count_seg_display
  import count_seg_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter int PRESC_W  = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] cnt,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);

  logic [PRESC_W-1:0] r_presc;
  logic               r_step;
  logic               r_first;
  dig_t               r_state;
  dig_t               w_state_nxt;
  logic [3:0]         r_snap;
  logic [3:0]         w_snap_nxt;
  logic               w_enter0;
  logic               w_tens;
  logic [3:0]         w_ones;
  logic [6:0]         w_seg_ones;
  logic [6:0]         w_seg_tens;
  logic [3:0]         w_an_nxt;
  logic [6:0]         w_seg_nxt;
  logic               w_dp_nxt;
  logic [3:0]         r_an;
  logic [6:0]         r_seg;
  logic               r_dp;

  // Step is registered, so each digit is held for exactly SCAN_DIV edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc <= '0;
      r_step  <= 1'b0;
      r_first <= 1'b1;
    end else begin
      r_first <= 1'b0;
      if (r_presc == PRESC_LAST) begin
        r_presc <= '0;
        r_step  <= 1'b1;
      end else begin
        r_presc <= r_presc + 1'b1;
        r_step  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= DIG3;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_first)     w_state_nxt = DIG0;
    else if (r_step) w_state_nxt = dig_t'(r_state + 2'd1);
  end

  assign w_enter0   = (r_first || r_step) && (w_state_nxt == DIG0);
  assign w_snap_nxt = w_enter0 ? cnt : r_snap;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_snap <= 4'd15;
    else      r_snap <= w_snap_nxt;
  end

  // Outputs are built from the next state and snapshot so they land on the entry edge.
  assign w_tens = (w_snap_nxt >= 4'd10);
  assign w_ones = w_tens ? (w_snap_nxt - 4'd10) : w_snap_nxt;

  bcd_to_seg u_ones (.i_digit(w_ones),                .o_seg(w_seg_ones));
  bcd_to_seg u_tens (.i_digit({3'b000, w_tens}),      .o_seg(w_seg_tens));

`ifdef COUNT_SEG_CHANGE_DP_EN
  logic r_chg;
  logic w_chg_nxt;

  assign w_chg_nxt = w_enter0 ? (cnt != r_snap) : r_chg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_chg <= 1'b0;
    else      r_chg <= w_chg_nxt;
  end

  assign w_dp_nxt = !((w_state_nxt == DIG0) && w_chg_nxt);
`else
  assign w_dp_nxt = 1'b1;
`endif

  always_comb begin
    w_an_nxt  = an_for(w_state_nxt);
    w_seg_nxt = SEG_BLANK;
    case (w_state_nxt)
      DIG0:    w_seg_nxt = w_seg_ones;
      DIG1:    w_seg_nxt = w_tens ? w_seg_tens : SEG_BLANK;
      default: w_seg_nxt = SEG_BLANK;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_an  <= AN_OFF;
      r_seg <= SEG_BLANK;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= w_an_nxt;
      r_seg <= w_seg_nxt;
      r_dp  <= w_dp_nxt;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = r_dp;

endmodule

// File: tb/tb_count_seg_display.sv
// Bench for count_seg_display: frame-level model checked every cycle plus literal spot checks.
module tb_count_seg_display;

  localparam int SD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] cnt = 4'd15;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int checks = 0;
  int failures = 0;

  count_seg_display #(.SCAN_DIV(SD), .PRESC_W(2)) dut (
    .clk(clk), .rst(rst), .cnt(cnt), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  logic [6:0] enc [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                           7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

`ifdef COUNT_SEG_CHANGE_DP_EN
  localparam bit DP_FEAT = 1'b1;
`else
  localparam bit DP_FEAT = 1'b0;
`endif

  // Model: m_k = edges seen since release; a frame is 4*SD edges starting with capture.
  int         m_k = 0;
  bit         m_active = 1'b0;
  logic [3:0] m_snap = 4'd15;
  bit         m_chg = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_k      <= 0;
      m_active <= 1'b0;
      m_snap   <= 4'd15;
      m_chg    <= 1'b0;
    end else begin
      if (m_k % (4 * SD) == 0) begin
        m_chg  <= (cnt != m_snap);
        m_snap <= cnt;
      end
      m_active <= 1'b1;
      m_k      <= m_k + 1;
    end
  end

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int d;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    e_an = 4'b1111; e_seg = 7'b1111111; e_dp = 1'b1;
    if (m_active) begin
      d = ((m_k - 1) / SD) % 4;
      e_an = 4'b1111;
      e_an[d] = 1'b0;
      if (d == 0) begin
        e_seg = enc[m_snap % 10];
        e_dp  = !(DP_FEAT && m_chg);
      end else if (d == 1 && m_snap >= 10) begin
        e_seg = enc[m_snap / 10];
      end
    end
    chk("model_an", {3'b000, an}, {3'b000, e_an});
    chk("model_seg", seg, e_seg);
    chk("model_dp", {6'b0, dp}, {6'b0, e_dp});
  end

  // Advance to the falling edge just after release-relative edge k.
  task automatic at(input int k);
    int n = 0;
    while (m_k != k + 1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (m_k != k + 1) begin
      failures++;
      $display("FAIL at_timeout: m_k=%0d expected %0d", m_k, k + 1);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_an", {3'b000, an}, 7'b0001111);
    chk("reset_seg", seg, 7'b1111111);
    rst = 1'b1;
    at(0);
    chk("first_an", {3'b000, an}, 7'b0001110);
    chk("first_seg5", seg, 7'b0010010);
    at(4);
    chk("dig1_an", {3'b000, an}, 7'b0001101);
    chk("dig1_seg1", seg, 7'b1111001);
    at(8);
    chk("dig2_seg", seg, 7'b1111111);
    cnt = 4'd7;
    at(16);
    chk("seven_seg", seg, 7'b1111000);
    cnt = 4'd9;
    at(20);
    chk("seven_tens_an", {3'b000, an}, 7'b0001101);
    chk("seven_tens_blank", seg, 7'b1111111);
    at(32);
    chk("nine_seg", seg, 7'b0010000);
    at(38);
    cnt = 4'd3;
    at(44);
    chk("no_tear_dig3", seg, 7'b1111111);
    at(48);
    chk("three_seg", seg, 7'b0110000);
    at(53);
    #1 rst = 1'b0;
    #1;
    chk("async_an", {3'b000, an}, 7'b0001111);
    chk("async_seg", seg, 7'b1111111);
    chk("async_dp", {6'b0, dp}, 7'd1);
    repeat (3) @(negedge clk);
    cnt = 4'd12;
    @(negedge clk);
    rst = 1'b1;
    at(0);
    chk("rerun_an", {3'b000, an}, 7'b0001110);
    chk("rerun_seg2", seg, 7'b0100100);
    chk("rerun_dp", {6'b0, dp}, {6'b0, !DP_FEAT});
    cnt = 4'd4;
    at(4);
    chk("rerun_tens1", seg, 7'b1111001);
    at(16);
    chk("four_seg", seg, 7'b0011001);
    cnt = 4'd5;
    at(32);
    chk("five_seg", seg, 7'b0010010);
    chk("five_dp_chg", {6'b0, dp}, {6'b0, !DP_FEAT});
    at(36);
    chk("five_dp_dig1", {6'b0, dp}, 7'd1);
    at(48);
    chk("five_dp_steady", {6'b0, dp}, 7'd1);
    cnt = 4'd0;
    at(64);
    chk("zero_seg", seg, 7'b1000000);
    cnt = 4'd15;
    at(80);
    chk("wrap15_seg", seg, 7'b0010010);
    at(84);
    chk("wrap15_tens", seg, 7'b1111001);
    cnt = 4'd10;
    at(96);
    chk("ten_ones", seg, 7'b1000000);
    at(100);
    chk("ten_tens", seg, 7'b1111001);
    at(112);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
